// File: rtl/nexys4_display_pkg.sv
// Shared constants, frame layout and hex glyph table for the Nexys4 SPI
// seven-segment display driver.
package nexys4_display_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_BITS   = 5;
  localparam int unsigned CNT_SAT    = 17;
  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned IDX_BITS   = 3;

  localparam logic [3:0] CMD_MASK  = 4'h0;
  localparam logic [3:0] CMD_DIGIT = 4'h1;

  // Frame field positions: cmd [15:12], addr [11:8], data [7:0].
  typedef struct packed {
    logic [3:0] cmd;
    logic [3:0] addr;
    logic [7:0] data;
  } frame_t;

  typedef struct packed {
    logic       dp;
    logic [3:0] hex;
  } digit_t;

  // Standard hex glyphs, returned as {g,f,e,d,c,b,a} active-high.
  function automatic logic [6:0] seg7(input logic [3:0] hex);
    logic [6:0] s;
    case (hex)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/nexys4_display_spi_rx.sv
// SPI slave front end: pin synchronisers, 16-bit receive with exact-length
// commit, and readback of the last committed frame on MISO.
module nexys4_display_spi_rx
  import nexys4_display_pkg::*;
(
  input  logic                  block_clk_i,
  input  logic                  rst_i,
  input  logic                  spi_sclk_i,
  input  logic                  spi_ss_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  frame_valid,
  output logic [FRAME_BITS-1:0] frame
);

  // [1:0] form the synchroniser, [2] holds the previous synchronised value.
  logic [2:0] sclk_sync;
  logic [2:0] ss_sync;
  logic [1:0] mosi_sync;

  logic                  active;
  logic [CNT_BITS-1:0]   bit_cnt;
  logic [FRAME_BITS-1:0] rx_shift;
  logic [FRAME_BITS-1:0] tx_shift;
  logic [FRAME_BITS-1:0] tx_next;

  logic sclk_rise;
  logic sclk_fall;
  logic ss_low;
  logic ss_fall;
  logic ss_rise;

  // Synchronisers track the pins through reset so no false SS edge follows it.
  always_ff @(posedge block_clk_i) begin
    sclk_sync <= {sclk_sync[1:0], spi_sclk_i};
    ss_sync   <= {ss_sync[1:0], spi_ss_i};
    mosi_sync <= {mosi_sync[0], spi_mosi_i};
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign ss_low    = ~ss_sync[1];
  assign ss_fall   = ~ss_sync[1] & ss_sync[2];
  assign ss_rise   = ss_sync[1] & ~ss_sync[2];

  // Transmit register: load on frame start, shift on SCLK falling edges.
  always_comb begin
    tx_next = tx_shift;
    if (ss_fall) begin
      tx_next = frame;
    end else if (active && ss_low && sclk_fall) begin
      tx_next = {tx_shift[FRAME_BITS-2:0], 1'b0};
    end
  end

  always_ff @(posedge block_clk_i) begin
    if (rst_i) begin
      active      <= 1'b0;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
      spi_miso_o  <= 1'b1;
    end else begin
      frame_valid <= 1'b0;
      tx_shift    <= tx_next;
      spi_miso_o  <= ss_low ? tx_next[FRAME_BITS-1] : 1'b1;
      if (ss_fall) begin
        active   <= 1'b1;
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (ss_rise) begin
        // Close takes priority over any coincident SCLK edge.
        active <= 1'b0;
        if (active && (bit_cnt == CNT_BITS'(FRAME_BITS))) begin
          frame       <= rx_shift;
          frame_valid <= 1'b1;
        end
      end else if (active && ss_low && sclk_rise) begin
        rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_sync[1]};
        if (bit_cnt != CNT_BITS'(CNT_SAT)) begin
          bit_cnt <= bit_cnt + CNT_BITS'(1);
        end
      end
    end
  end

endmodule

// File: rtl/nexys4_display.sv
// Eight-digit common-anode seven-segment driver: SPI-written digit registers
// and enable mask, time-multiplexed onto registered anode/cathode pins.
module nexys4_display
  import nexys4_display_pkg::*;
#(
  parameter int unsigned REFRESH_BITS = 13
)
(
  input  logic       block_clk_i,
  input  logic       rst_i,
  input  logic       spi_sclk_i,
  input  logic       spi_ss_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic [7:0] segment_o,
  output logic [7:0] digit_o
);

  logic                  frame_valid;
  logic [FRAME_BITS-1:0] rx_frame;
  frame_t                cmd_frame;

  digit_t                  digits [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   enable_mask;
  logic [REFRESH_BITS-1:0] prescaler;
  logic [IDX_BITS-1:0]     scan_idx;
  logic [IDX_BITS-1:0]     scan_idx_next;
  logic [7:0]              digit_next;
  logic [7:0]              segment_next;

  nexys4_display_spi_rx u_spi_rx (
    .block_clk_i (block_clk_i),
    .rst_i       (rst_i),
    .spi_sclk_i  (spi_sclk_i),
    .spi_ss_i    (spi_ss_i),
    .spi_mosi_i  (spi_mosi_i),
    .spi_miso_o  (spi_miso_o),
    .frame_valid (frame_valid),
    .frame       (rx_frame)
  );

  assign cmd_frame = frame_t'(rx_frame);

  // Command decode into digit registers and enable mask.
  always_ff @(posedge block_clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digits[i] <= '0;
      end
      enable_mask <= '1;
    end else if (frame_valid) begin
      case (cmd_frame.cmd)
        CMD_DIGIT: begin
          if (!cmd_frame.addr[3]) begin
            digits[cmd_frame.addr[2:0]] <= {cmd_frame.data[4], cmd_frame.data[3:0]};
          end
        end
        CMD_MASK: enable_mask <= cmd_frame.data;
        default:  ;
      endcase
    end
  end

  // Output encode follows the index it will hold after this edge.
  assign scan_idx_next = (&prescaler) ? scan_idx + IDX_BITS'(1) : scan_idx;

  always_comb begin
    digit_next   = 8'hFF;
    segment_next = ~{digits[scan_idx_next].dp, seg7(digits[scan_idx_next].hex)};
    if (enable_mask[scan_idx_next]) begin
      digit_next = ~(8'(1) << scan_idx_next);
    end
  end

  always_ff @(posedge block_clk_i) begin
    if (rst_i) begin
      prescaler <= '0;
      scan_idx  <= '0;
      digit_o   <= 8'hFF;
      segment_o <= 8'hFF;
    end else begin
      prescaler <= prescaler + REFRESH_BITS'(1);
      scan_idx  <= scan_idx_next;
      digit_o   <= digit_next;
      segment_o <= segment_next;
    end
  end

endmodule

// File: tb/tb_nexys4_display.sv
// Bench for nexys4_display: table of SPI frames with hand-computed results,
// a reset-abort sequence, and random frames against a behavioural model.
module tb_nexys4_display;

  localparam int RB = 4;
  localparam int PH = 6;
  localparam int SCAN = 8 << RB;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       ss;
  logic       mosi;
  logic       miso;
  logic [7:0] seg;
  logic [7:0] dig;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int         m_hex [8];
  bit         m_dp [8];
  logic [7:0] m_mask;
  logic [15:0] m_last;
  logic [7:0] glyph [16];

  typedef struct {
    int          nbits;
    logic [15:0] frame;
    bit          hold;
    logic [15:0] exp_rb;
    int          probe;
    logic [7:0]  exp_an;
    logic [7:0]  exp_seg;
  } vec_t;

  vec_t vecs [$];

  nexys4_display #(.REFRESH_BITS(RB)) dut (
    .block_clk_i (clk),
    .rst_i       (rst),
    .spi_sclk_i  (sclk),
    .spi_ss_i    (ss),
    .spi_mosi_i  (mosi),
    .spi_miso_o  (miso),
    .segment_o   (seg),
    .digit_o     (dig)
  );

  always #5 clk = ~clk;

  // Clocks since reset release; the display index is bits [RB+2:RB] of it.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_hex[i] = 0;
      m_dp[i]  = 1'b0;
    end
    m_mask = 8'hFF;
    m_last = 16'h0000;
  endtask

  task automatic model_commit(input logic [15:0] f);
    int a;
    m_last = f;
    a = int'(f[10:8]);
    if (f[15:12] == 4'h1 && !f[11]) begin
      m_hex[a] = int'(f[3:0]);
      m_dp[a]  = f[4];
    end else if (f[15:12] == 4'h0) begin
      m_mask = f[7:0];
    end
  endtask

  function automatic logic [7:0] exp_an(input int idx);
    logic [7:0] one = 8'd1;
    return m_mask[idx] ? ~(one << idx) : 8'hFF;
  endfunction

  function automatic logic [7:0] exp_seg(input int idx);
    return glyph[m_hex[idx]] & (m_dp[idx] ? 8'h7F : 8'hFF);
  endfunction

  // Full scan compared against the model, one comparison per clock.
  task automatic scan_check(input string name);
    int idx;
    for (int c = 0; c < SCAN; c++) begin
      @(negedge clk);
      idx = (cyc >> RB) & 7;
      check(name, {24'h0, dig, seg}, {24'h0, exp_an(idx), exp_seg(idx)});
    end
  endtask

  task automatic probe_check(input string name, input int probe,
                             input logic [7:0] an, input logic [7:0] sg);
    bit found = 1'b0;
    for (int c = 0; c < SCAN + 2 && !found; c++) begin
      @(negedge clk);
      if (((cyc >> RB) & 7) == probe) found = 1'b1;
    end
    check({name, "_found"}, 32'(found), 32'd1);
    check({name, "_digit"}, 32'(dig), 32'(an));
    check({name, "_seg"}, 32'(sg), 32'(seg)) ;
  endtask

  // Clock n bits of val MSB first, sampling MISO just before each rise.
  task automatic spi_bits(input int n, input logic [15:0] val, output logic [15:0] rb);
    rb = '0;
    for (int i = 0; i < n; i++) begin
      mosi = (i < 16) ? val[15 - i] : 1'b0;
      repeat (PH) @(negedge clk);
      if (i < 16) rb = {rb[14:0], miso};
      sclk = 1'b1;
      repeat (PH) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_send(input int n, input logic [15:0] val, input bit hold,
                          output logic [15:0] rb);
    @(negedge clk);
    if (!hold) ss = 1'b0;
    repeat (8) @(negedge clk);
    spi_bits(n, val, rb);
    repeat (PH) @(negedge clk);
    ss   = 1'b1;
    mosi = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_rb(input string name, input int n, input logic [15:0] rb,
                          input logic [15:0] exp);
    int k = (n > 16) ? 16 : n;
    logic [31:0] e = 32'(exp) >> (16 - k);
    logic [31:0] m = (32'd1 << k) - 32'd1;
    check(name, 32'(rb) & m, e);
  endtask

  task automatic add(input int n, input logic [15:0] f, input bit h, input logic [15:0] rb,
                     input int p, input logic [7:0] an, input logic [7:0] sg);
    vec_t v;
    v.nbits = n; v.frame = f; v.hold = h; v.exp_rb = rb;
    v.probe = p; v.exp_an = an; v.exp_seg = sg;
    vecs.push_back(v);
  endtask

  // Send one frame, compare readback, and update the model if it commits.
  task automatic run_frame(input string name, input int n, input logic [15:0] f, input bit h);
    logic [15:0] rb;
    logic [15:0] exp_rb = h ? 16'hFFFF : m_last;
    spi_send(n, f, h, rb);
    check_rb({name, "_rb"}, n, rb, exp_rb);
    if (n == 16 && !h) model_commit(f);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rb;
    glyph = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    model_reset();
    rst = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b1;

    add(16, 16'h100C, 0, 16'h0000, 0, 8'hFE, 8'hC6);
    add( 8, 16'h16EE, 0, 16'h100C, 0, 8'hFE, 8'hC6);
    add(16, 16'h11AA, 0, 16'h100C, 1, 8'hFD, 8'h88);
    add(16, 16'h1213, 0, 16'h11AA, 2, 8'hFB, 8'h30);
    add(16, 16'h1314, 0, 16'h1213, 3, 8'hF7, 8'h19);
    add(16, 16'h1415, 0, 16'h1314, 4, 8'hEF, 8'h12);
    add(16, 16'h040F, 0, 16'h1415, 4, 8'hFF, 8'h12);
    add(16, 16'h1F77, 0, 16'h040F, 1, 8'hFD, 8'h88);
    add(16, 16'h5123, 0, 16'h1F77, 2, 8'hFB, 8'h30);
    add(16, 16'h1177, 1, 16'hFFFF, 1, 8'hFD, 8'h88);
    add(17, 16'h1005, 0, 16'h5123, 0, 8'hFE, 8'hC6);
    add(48, 16'h1005, 0, 16'h5123, 0, 8'hFE, 8'hC6);
    add(16, 16'h1801, 0, 16'h5123, 0, 8'hFE, 8'hC6);
    add(16, 16'h00FF, 0, 16'h1801, 7, 8'h7F, 8'hC0);
    add(16, 16'h1790, 0, 16'h00FF, 7, 8'h7F, 8'h40);

    repeat (4) @(negedge clk);
    check("reset_outputs", {23'h0, miso, dig, seg}, {23'h0, 1'b1, 8'hFF, 8'hFF});
    rst = 1'b0;
    #1;
    check("first_cycle_after_reset", {16'h0, dig, seg}, 32'h0000FFFF);
    scan_check("reset_scan");

    foreach (vecs[v]) begin
      spi_send(vecs[v].nbits, vecs[v].frame, vecs[v].hold, rb);
      check_rb($sformatf("vec%0d_rb", v), vecs[v].nbits, rb, vecs[v].exp_rb);
      if (vecs[v].nbits == 16 && !vecs[v].hold) model_commit(vecs[v].frame);
      probe_check($sformatf("vec%0d", v), vecs[v].probe, vecs[v].exp_an, vecs[v].exp_seg);
      scan_check($sformatf("vec%0d_scan", v));
    end

    // Reset in the middle of a frame, then keep clocking with SS still low.
    @(negedge clk);
    ss = 1'b0;
    repeat (8) @(negedge clk);
    spi_bits(8, 16'h1122, rb);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midframe_reset_outputs", {23'h0, miso, dig, seg}, {23'h0, 1'b1, 8'hFF, 8'hFF});
    rst = 1'b0;
    model_reset();
    #1;
    check("midframe_first_cycle", {16'h0, dig, seg}, 32'h0000FFFF);
    repeat (8) @(negedge clk);
    spi_bits(8, 16'h2200, rb);
    check("aborted_tail_miso", 32'(rb[7:0]), 32'h00);
    repeat (PH) @(negedge clk);
    ss = 1'b1;
    repeat (8) @(negedge clk);
    scan_check("after_abort_scan");
    run_frame("post_reset_1122", 16, 16'h1122, 1'b0);
    probe_check("post_reset_digit1", 1, 8'hFD, 8'hA4);
    run_frame("readback_1122", 16, 16'h00F0, 1'b0);
    scan_check("post_reset_scan");

    // Random frames of mixed length and command.
    for (int r = 0; r < 16; r++) begin
      int          kind = $urandom_range(0, 9);
      int          csel = $urandom_range(0, 4);
      int          nb = 16;
      bit          hold = 1'b0;
      logic [15:0] f = 16'($urandom);
      if (csel < 3)       f[15:12] = 4'h1;
      else if (csel == 3) f[15:12] = 4'h0;
      if (kind == 0)      nb = $urandom_range(1, 15);
      else if (kind == 1) nb = $urandom_range(17, 20);
      else if (kind == 2) hold = 1'b1;
      run_frame($sformatf("rand%0d", r), nb, f, hold);
      scan_check($sformatf("rand%0d_scan", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
